// File: rtl/mem_responder.sv
// mem_responder
//
// Word-addressed 32-bit synchronous memory that answers the datapath's
// Read/Write strobes. A request is captured in IDLE (operation, address and
// write data are latched), optionally waits WAIT_STATES cycles, performs the
// access in ACCESS, then sits in HOLD until both strobes are seen low. The
// control sequence can stall on Done/Busy instead of relying on fixed timing.
//
// Optional feature macro: MEM_BOUNDS_EN
//   defined   : a latched address with MAR_q >= DEPTH (full 32-bit compare)
//               pulses Err with Done; writes are suppressed, reads return 0.
//   undefined : no compare logic, Err is tied to 0, addresses alias.
//
// Parameters:
//   DEPTH       number of 32-bit words implemented
//   ADDR_W      address bits used to index the array (2**ADDR_W >= DEPTH)
//   WAIT_STATES extra cycles between capture and access (0..15)
//
// Ports:
//   Clock      in   1  system clock, rising edge
//   Clear      in   1  asynchronous active-low reset
//   Read       in   1  read request strobe
//   Write      in   1  write request strobe (wins over Read)
//   MAR_q      in  32  address; bits [ADDR_W-1:0] index the array
//   MDR_q      in  32  write data
//   Mdata_out  out 32  registered read data, holds last read value
//   Done       out  1  one-cycle pulse when an access completes
//   Busy       out  1  high from capture until return to IDLE
//   Err        out  1  out-of-range pulse alongside Done (MEM_BOUNDS_EN only)

module mem_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] MAR_q,
  input  logic [31:0] MDR_q,
  output logic [31:0] Mdata_out,
  output logic        Done,
  output logic        Busy,
  output logic        Err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t              state;
  logic [3:0]          wait_cnt;
  logic                op_write;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;
  logic                in_range;

  logic [31:0]         mem [DEPTH];

  // Address bits above the index are only consumed by the bounds compare.
  logic unused_mar_hi;
  assign unused_mar_hi = ^MAR_q[31:ADDR_W];

`ifdef MEM_BOUNDS_EN
  logic oor_q;
  logic err_q;
  assign in_range = ~oor_q;
  assign Err      = err_q;
`else
  assign in_range = 1'b1;
  assign Err      = 1'b0;
`endif

  // Handshake FSM with registered outputs. The counter is loaded with
  // WAIT_STATES at capture and WAIT hands over to ACCESS on the same edge
  // the count reaches 0, so Done lands WAIT_STATES+1 cycles after capture.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      op_write  <= 1'b0;
      addr_q    <= '0;
      data_q    <= 32'd0;
      Mdata_out <= 32'd0;
      Done      <= 1'b0;
      Busy      <= 1'b0;
`ifdef MEM_BOUNDS_EN
      oor_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
`ifdef MEM_BOUNDS_EN
      err_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (Read || Write) begin
            // Write wins a simultaneous request; the read is simply dropped.
            op_write <= Write;
            addr_q   <= MAR_q[ADDR_W-1:0];
            data_q   <= MDR_q;
            wait_cnt <= WS_INIT;
            Busy     <= 1'b1;
`ifdef MEM_BOUNDS_EN
            oor_q    <= (MAR_q >= 32'(DEPTH));
`endif
            state    <= (WS_INIT == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          // Strobes are ignored here; the request is already latched.
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          Done <= 1'b1;
          if (!op_write) begin
            Mdata_out <= in_range ? mem[addr_q] : 32'd0;
          end
`ifdef MEM_BOUNDS_EN
          err_q <= oor_q;
`endif
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Both strobes must be seen low before a new request is accepted.
          if (!Read && !Write) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array write port. Not reset: contents survive Clear. A Clear asserted
  // during ACCESS forces the FSM out of ACCESS before the edge, so the write
  // is never committed.
  always_ff @(posedge Clock) begin
    if (state == S_ACCESS && op_write && in_range) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//
// Directed bench for mem_responder. Three instances (WAIT_STATES = 0, 1, 3)
// share every input, so one stimulus sequence exercises all latencies; each
// step leaves a long idle tail so every instance is back in IDLE before the
// next request. Expected values are hand-computed constants.

module tb_mem_responder;

  logic        Clock;
  logic        Clear;
  logic        Read;
  logic        Write;
  logic [31:0] MAR_q;
  logic [31:0] MDR_q;
  logic [2:0]  done_v;
  logic [2:0]  busy_v;
  logic [2:0]  err_v;
  logic [31:0] mdata [3];

  int n_compared;
  int n_mismatched;

  // Per-instance observations of the most recent transaction window.
  int done_at  [3];
  int done_cnt [3];
  int busy_cnt [3];
  int err_cnt  [3];

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(0)) u0 (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
    .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdata_out(mdata[0]),
    .Done(done_v[0]), .Busy(busy_v[0]), .Err(err_v[0])
  );

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(1)) u1 (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
    .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdata_out(mdata[1]),
    .Done(done_v[1]), .Busy(busy_v[1]), .Err(err_v[1])
  );

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(3)) u3 (
    .Clock(Clock), .Clear(Clear), .Read(Read), .Write(Write),
    .MAR_q(MAR_q), .MDR_q(MDR_q), .Mdata_out(mdata[2]),
    .Done(done_v[2]), .Busy(busy_v[2]), .Err(err_v[2])
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Present a request at the coming edge (capture edge = cycle 0), keep the
  // strobes up for 'hold' sampled edges, then watch a fixed 16-cycle window.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int hold);
    for (int k = 0; k < 3; k++) begin
      done_at[k]  = -1;
      done_cnt[k] = 0;
      busy_cnt[k] = 0;
      err_cnt[k]  = 0;
    end
    Read  = rd;
    Write = wr;
    MAR_q = addr;
    MDR_q = data;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == hold - 1) begin
        Read  = 1'b0;
        Write = 1'b0;
      end
      for (int k = 0; k < 3; k++) begin
        if (done_v[k]) begin
          done_cnt[k]++;
          if (done_at[k] < 0) done_at[k] = i;
        end
        if (busy_v[k]) busy_cnt[k]++;
        if (err_v[k])  err_cnt[k]++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int ws_tab [3];
    int after_rst_done;
    ws_tab = '{0, 1, 3};
    n_compared   = 0;
    n_mismatched = 0;
    Clear = 1'b0;
    Read  = 1'b0;
    Write = 1'b0;
    MAR_q = 32'd0;
    MDR_q = 32'd0;

    // Reset state
    tick();
    tick();
    checkOutput("reset_done", 32'(done_v), 32'd0);
    checkOutput("reset_busy", 32'(busy_v), 32'd0);
    checkOutput("reset_err",  32'(err_v),  32'd0);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("reset_mdata_u%0d", k), mdata[k], 32'd0);
    Clear = 1'b1;
    tick();
    $display("[TB] reset released");

    // Reset then write, then read back through the WAIT_STATES=1 instance
    applyStimulus(1'b0, 1'b1, 32'h0000_0055, 32'hDEAD_BEEF, 1);
    checkOutput("wr55_done_at_u1",  32'(done_at[1]),  32'd2);
    checkOutput("wr55_done_cnt_u1", 32'(done_cnt[1]), 32'd1);
    checkOutput("wr55_mdata_u1",    mdata[1],         32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0055, 32'd0, 1);
    checkOutput("rd55_done_at_u1", 32'(done_at[1]), 32'd2);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("rd55_mdata_u%0d", k), mdata[k], 32'hDEAD_BEEF);

    // Read latency sweep over WAIT_STATES 0, 1, 3
    applyStimulus(1'b0, 1'b1, 32'h0000_0012, 32'hCAFE_0012, 1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0012, 32'd0, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("sweep_done_at_u%0d", k),  32'(done_at[k]),  32'(ws_tab[k] + 1));
      checkOutput($sformatf("sweep_done_cnt_u%0d", k), 32'(done_cnt[k]), 32'd1);
      checkOutput($sformatf("sweep_busy_cnt_u%0d", k), 32'(busy_cnt[k]), 32'(ws_tab[k] + 2));
      checkOutput($sformatf("sweep_mdata_u%0d", k),    mdata[k],          32'hCAFE_0012);
    end

    // Simultaneous strobes: write wins, Mdata_out untouched, one Done
    applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h0000_00A5, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("both_done_cnt_u%0d", k), 32'(done_cnt[k]), 32'd1);
      checkOutput($sformatf("both_mdata_u%0d", k),    mdata[k],          32'hCAFE_0012);
    end
    applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'd0, 1);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("rd10_mdata_u%0d", k), mdata[k], 32'h0000_00A5);

    // Read held for 6 cycles: single access, Busy until Read is seen low
    applyStimulus(1'b1, 1'b0, 32'h0000_0055, 32'd0, 6);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("hold_done_cnt_u%0d", k), 32'(done_cnt[k]), 32'd1);
      checkOutput($sformatf("hold_busy_cnt_u%0d", k), 32'(busy_cnt[k]), 32'd6);
      checkOutput($sformatf("hold_mdata_u%0d", k),    mdata[k],          32'hDEAD_BEEF);
    end

    // Reset during the second WAIT cycle of the WAIT_STATES=3 instance
    applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 1);
    Write = 1'b1;
    MAR_q = 32'h0000_0020;
    MDR_q = 32'h1234_5678;
    tick();
    Write = 1'b0;
    tick();
    #2;
    Clear = 1'b0;
    #1;
    checkOutput("rstwait_done", 32'(done_v), 32'd0);
    checkOutput("rstwait_busy", 32'(busy_v), 32'd0);
    checkOutput("rstwait_err",  32'(err_v),  32'd0);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("rstwait_mdata_u%0d", k), mdata[k], 32'd0);
    tick();
    Clear = 1'b1;
    after_rst_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_v != 3'b000) after_rst_done++;
    end
    checkOutput("rstwait_no_done", 32'(after_rst_done), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'd0, 1);
    // WS=0 committed at its ACCESS edge before Clear fell; the others did not
    checkOutput("rstwait_rd20_u0", mdata[0], 32'h1234_5678);
    checkOutput("rstwait_rd20_u1", mdata[1], 32'h0BAD_F00D);
    checkOutput("rstwait_rd20_u3", mdata[2], 32'h0BAD_F00D);

    // Out-of-range address 0x200 against DEPTH=512
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_0000, 1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 1);
`ifdef MEM_BOUNDS_EN
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("oobwr_err_u%0d", k),  32'(err_cnt[k]),  32'd1);
      checkOutput($sformatf("oobwr_done_u%0d", k), 32'(done_cnt[k]), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("oobrd_err_u%0d", k), 32'(err_cnt[k]), 32'd1);
      checkOutput($sformatf("oobrd_mdata_u%0d", k), mdata[k], 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("rd0_err_u%0d", k), 32'(err_cnt[k]), 32'd0);
      checkOutput($sformatf("rd0_mdata_u%0d", k), mdata[k], 32'h5A5A_0000);
    end
`else
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("aliaswr_err_u%0d", k), 32'(err_cnt[k]), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'd0, 1);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("aliasrd200_mdata_u%0d", k), mdata[k], 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 32'd0, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("aliasrd0_err_u%0d", k), 32'(err_cnt[k]), 32'd0);
      checkOutput($sformatf("aliasrd0_mdata_u%0d", k), mdata[k], 32'hFFFF_FFFF);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
